// File: rtl/tselect_cfg_arbiter.sv
// rtl/tselect_cfg_arbiter.sv - round-robin, vblank-gated write arbiter and storage for the tile-select table
//
// Requesters post single-entry writes. One is picked round-robin and committed
// only while the registered write window (vertical blanking) is open. The
// display path reads the table combinationally every pixel.
//
// Ports:
//   clk       pixel clock (divided); all logic on the rising edge
//   rst       asynchronous, active-low reset
//   hcount    horizontal pixel counter (not needed for the window decode)
//   vcount    vertical line counter; window is VSTART <= vcount < VEND
//   req       per-requester level write request
//   req_addr  packed addresses, requester i at [i*AW +: AW]
//   req_data  packed write data, requester i at [i*DW +: DW]
//   gnt       registered one-hot, one-cycle grant pulse
//   rd_addr   display-side read address
//   rd_data   table[rd_addr], combinational
//   win       registered write-window flag
//   wr_count  saturating count of commits since the window opened
module tselect_cfg_arbiter #(
  parameter int NREQ   = 4,
  parameter int AW     = 4,
  parameter int DW     = 4,
  parameter int VSTART = 480,
  parameter int VEND   = 525
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [9:0]        hcount,
  input  logic [9:0]        vcount,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]   gnt,
  input  logic [AW-1:0]     rd_addr,
  output logic [DW-1:0]     rd_data,
  output logic              win,
  output logic [7:0]        wr_count
);

  localparam int PW    = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int DEPTH = 1 << AW;

  typedef enum logic [1:0] {IDLE, GRANT, HOLD} state_t;

  state_t          state;
  logic [PW-1:0]   rr_ptr;
  logic [PW-1:0]   sel;
  logic [PW-1:0]   sel_nxt;
  logic [AW-1:0]   addr_q;
  logic [AW-1:0]   addr_nxt;
  logic [DW-1:0]   data_q;
  logic [DW-1:0]   data_nxt;
  logic [DW-1:0]   table_q [DEPTH];
  logic            in_win;
  logic            win_rise;
  logic            commit;
  logic            found;
  logic            unused_hcount;

  // The window decode is line-based only; hcount is accepted for interface
  // compatibility with the timing controller.
  assign unused_hcount = ^hcount;

  assign in_win   = (vcount >= 10'(VSTART)) && (vcount < 10'(VEND));
  assign win_rise = in_win && !win;
  assign commit   = (state == GRANT);
  assign rd_data  = table_q[rd_addr];

  // Round-robin pick: scan offsets k = 0.. from rr_ptr; the inner loop over
  // constant i keeps every select a static index.
  always_comb begin
    sel_nxt  = '0;
    addr_nxt = '0;
    data_nxt = '0;
    found    = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!found && req[i] && (((int'(rr_ptr) + k) % NREQ) == i)) begin
          found    = 1'b1;
          sel_nxt  = PW'(i);
          addr_nxt = req_addr[i*AW +: AW];
          data_nxt = req_data[i*DW +: DW];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      sel      <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      gnt      <= '0;
      win      <= 1'b0;
      wr_count <= 8'd0;
      for (int a = 0; a < DEPTH; a++) begin
        table_q[a] <= '0;
      end
    end else begin
      win <= in_win;

      // Window opening clears the count; a commit on that same edge counts as 1.
      if (win_rise) begin
        wr_count <= commit ? 8'd1 : 8'd0;
      end else if (commit && (wr_count != 8'hFF)) begin
        wr_count <= wr_count + 8'd1;
      end

      case (state)
        IDLE: begin
          // Capture only with the registered window open; once captured the
          // write finishes even if the window closes.
          if (win && found) begin
            sel    <= sel_nxt;
            addr_q <= addr_nxt;
            data_q <= data_nxt;
            gnt    <= NREQ'(1) << sel_nxt;
            state  <= GRANT;
          end
        end
        GRANT: begin
          gnt             <= '0;
          table_q[addr_q] <= data_q;
          rr_ptr          <= (int'(sel) == NREQ - 1) ? '0 : sel + 1'b1;
          state           <= HOLD;
        end
        HOLD: begin
          // Gives the granted requester a cycle to drop req before the next pick.
          state <= IDLE;
        end
        default: begin
          gnt   <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tselect_cfg_arbiter.sv
// tb/tb_tselect_cfg_arbiter.sv - self-checking bench for tselect_cfg_arbiter
module tb_tselect_cfg_arbiter;

  localparam int NREQ = 4;
  localparam int AW   = 4;
  localparam int DW   = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [9:0]  hcount = '0;
  logic [9:0]  vcount = '0;
  logic [3:0]  req = '0;
  logic [15:0] req_addr = '0;
  logic [15:0] req_data = '0;
  logic [3:0]  gnt;
  logic [3:0]  rd_addr = '0;
  logic [3:0]  rd_data;
  logic        win;
  logic [7:0]  wr_count;

  always #5 clk = ~clk;

  tselect_cfg_arbiter #(
    .NREQ(NREQ), .AW(AW), .DW(DW), .VSTART(480), .VEND(525)
  ) u_dut (
    .clk(clk), .rst(rst), .hcount(hcount), .vcount(vcount),
    .req(req), .req_addr(req_addr), .req_data(req_data),
    .gnt(gnt), .rd_addr(rd_addr), .rd_data(rd_data),
    .win(win), .wr_count(wr_count)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: transaction-level view of the arbiter.
  int         m_tbl [16];
  int         m_rr;
  int         m_cool;
  int         m_wr;
  bit         m_win;
  bit         m_pend;
  int         m_sel;
  int         m_addr;
  int         m_data;
  logic [3:0] m_gnt;

  function automatic void model_reset();
    for (int a = 0; a < 16; a++) m_tbl[a] = 0;
    m_rr = 0; m_cool = 0; m_wr = 0; m_win = 1'b0; m_pend = 1'b0;
    m_sel = 0; m_addr = 0; m_data = 0; m_gnt = '0;
  endfunction

  function automatic void model_edge();
    bit in_win;
    bit committed;
    bit f;
    int i;
    if (!rst) return;
    in_win    = (vcount >= 480) && (vcount < 525);
    committed = 1'b0;
    if (m_pend) begin
      m_tbl[m_addr] = m_data;
      m_rr          = (m_sel + 1) % NREQ;
      committed     = 1'b1;
      m_pend        = 1'b0;
    end
    if (in_win && !m_win) m_wr = committed ? 1 : 0;
    else if (committed && m_wr < 255) m_wr++;
    m_gnt = '0;
    if (m_cool > 0) begin
      m_cool--;
    end else if (m_win && req != 0) begin
      f = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
        i = (m_rr + k) % NREQ;
        if (!f && req[i]) begin
          f = 1'b1;
          m_sel = i;
        end
      end
      m_addr = int'(req_addr[m_sel*AW +: AW]);
      m_data = int'(req_data[m_sel*DW +: DW]);
      m_pend = 1'b1;
      m_gnt  = 4'b0001 << m_sel;
      m_cool = 2;
    end
    m_win = in_win;
  endfunction

  logic [3:0] dropped = '0;
  logic [3:0] reraise = '0;
  bit         rand_mode = 1'b0;
  int         step_no = 0;
  int         gq[$];
  int         gstep[$];

  // One clock: model at the rising edge, compare and drive at the falling edge.
  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    step_no++;
    check_eq("gnt", 32'(gnt), 32'(m_gnt));
    check_eq("win", 32'(win), 32'(m_win));
    check_eq("wr_count", 32'(wr_count), 32'(m_wr));
    check_eq("rd_data", 32'(rd_data), 32'(m_tbl[rd_addr]));
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        gq.push_back(i);
        gstep.push_back(step_no);
      end
    end
    req     = req | (dropped & reraise);
    dropped = gnt;
    req     = req & ~gnt;
    if (rand_mode) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!req[i] && !dropped[i] && $urandom_range(0, 3) == 0) begin
          req_addr[i*AW +: AW] = 4'($urandom);
          req_data[i*DW +: DW] = 4'($urandom);
          req[i] = 1'b1;
        end
      end
      rd_addr = 4'($urandom);
    end
  endtask

  task automatic run_until_grants(input int n, input int budget);
    int b = 0;
    while (gq.size() < n && b < budget) begin
      step();
      b++;
    end
    check_eq("grant_wait", 32'(gq.size() >= n), 32'd1);
  endtask

  task automatic drain();
    int b = 0;
    while ((req != 0 || b < 4) && b < 60) begin
      step();
      b++;
    end
    check_eq("drain", 32'(req), 32'd0);
  endtask

  function automatic int gq_at(input int k);
    return (k < gq.size()) ? gq[k] : -1;
  endfunction

  function automatic int gstep_at(input int k);
    return (k < gstep.size()) ? gstep[k] : -1;
  endfunction

  task automatic raise(input int i, input int a, input int d);
    req_addr[i*AW +: AW] = 4'(a);
    req_data[i*DW +: DW] = 4'(d);
    req[i] = 1'b1;
  endtask

  int base;
  int exp_rr0 [5] = '{0, 1, 2, 3, 0};
  int exp_rr2 [3] = '{3, 0, 1};

  initial begin
    // Reset and visible-region idle
    model_reset();
    rst = 1'b0; vcount = 10'd100; req = 4'b1111;
    req_addr = 16'h3210; req_data = 16'hABCD;
    repeat (2) @(negedge clk);
    check_eq("rst_gnt", 32'(gnt), 32'd0);
    check_eq("rst_win", 32'(win), 32'd0);
    check_eq("rst_wr_count", 32'(wr_count), 32'd0);
    for (int a = 0; a < 16; a++) begin
      rd_addr = 4'(a); #1;
      check_eq("rst_table", 32'(rd_data), 32'd0);
    end
    rd_addr = '0;
    rst = 1'b1;
    repeat (20) step();
    check_eq("no_gnt_visible", 32'(gq.size()), 32'd0);

    // Single write as the window opens
    req = '0; vcount = 10'd479; step();
    vcount = 10'd480; raise(2, 5, 9);
    gq.delete(); gstep.delete(); base = step_no;
    run_until_grants(1, 10);
    check_eq("single_id", 32'(gq_at(0)), 32'd2);
    check_eq("single_lat", 32'(gstep_at(0) - base), 32'd2);
    rd_addr = 4'd5;
    repeat (2) step();
    check_eq("single_rd", 32'(rd_data), 32'd9);
    check_eq("single_cnt", 32'(wr_count), 32'd1);

    // Round-robin from rr_ptr=0 (a grant to requester 3 wraps the pointer)
    vcount = 10'd481;
    raise(3, 15, 1); gq.delete(); gstep.delete();
    run_until_grants(1, 10);
    drain();
    for (int i = 0; i < NREQ; i++) raise(i, 8 + i, i + 1);
    reraise = 4'b1111; gq.delete(); gstep.delete();
    run_until_grants(5, 40);
    reraise = '0;
    for (int k = 0; k < 5; k++) begin
      check_eq("rr0_order", 32'(gq_at(k)), 32'(exp_rr0[k]));
      if (k > 0) check_eq("rr0_gap", 32'(gstep_at(k) - gstep_at(k-1)), 32'd3);
    end
    drain();
    raise(1, 2, 2); gq.delete();
    run_until_grants(1, 10);
    drain();
    raise(0, 1, 4); raise(1, 2, 5); raise(3, 3, 6);
    gq.delete(); gstep.delete();
    run_until_grants(3, 20);
    for (int k = 0; k < 3; k++) check_eq("rr2_order", 32'(gq_at(k)), 32'(exp_rr2[k]));
    drain();

    // Window close: last capture edge, then a request that must wait a frame
    vcount = 10'd524; step();
    vcount = 10'd0; raise(1, 2, 6);
    gq.delete(); gstep.delete(); base = step_no;
    run_until_grants(1, 5);
    check_eq("close_id", 32'(gq_at(0)), 32'd1);
    check_eq("close_lat", 32'(gstep_at(0) - base), 32'd1);
    check_eq("close_win", 32'(win), 32'd0);
    raise(3, 4, 11);
    for (int v = 1; v < 30; v++) begin
      vcount = 10'(v);
      step();
    end
    vcount = 10'd479; step();
    check_eq("close_wait", 32'(gq.size()), 32'd1);
    vcount = 10'd480; base = step_no;
    run_until_grants(2, 10);
    check_eq("next_id", 32'(gq_at(1)), 32'd3);
    check_eq("next_lat", 32'(gstep_at(1) - base), 32'd2);
    drain();

    // Collision on one address in a fresh window
    vcount = 10'd0; repeat (2) step();
    vcount = 10'd480; raise(0, 7, 3); raise(1, 7, 12);
    gq.delete(); gstep.delete();
    run_until_grants(2, 20);
    check_eq("coll_first", 32'(gq_at(0)), 32'd0);
    check_eq("coll_second", 32'(gq_at(1)), 32'd1);
    rd_addr = 4'd7;
    drain();
    check_eq("coll_rd", 32'(rd_data), 32'd12);
    check_eq("coll_cnt", 32'(wr_count), 32'd2);

    // Saturation then clear on the next window rise
    raise(0, 1, 1); reraise = 4'b0001; gq.delete(); gstep.delete();
    run_until_grants(300, 1000);
    reraise = '0;
    drain();
    check_eq("sat_cnt", 32'(wr_count), 32'd255);
    vcount = 10'd0; repeat (2) step();
    vcount = 10'd480; step();
    check_eq("clear_cnt", 32'(wr_count), 32'd0);

    // Asynchronous reset while a grant is high
    raise(2, 5, 13); gq.delete();
    run_until_grants(1, 10);
    check_eq("pre_rst_gnt", 32'(gnt), 32'h4);
    rst = 1'b0; #1;
    check_eq("async_gnt", 32'(gnt), 32'd0);
    check_eq("async_cnt", 32'(wr_count), 32'd0);
    check_eq("async_win", 32'(win), 32'd0);
    model_reset();
    for (int a = 0; a < 16; a++) begin
      rd_addr = 4'(a); #1;
      check_eq("async_table", 32'(rd_data), 32'd0);
    end
    repeat (2) step();
    rst = 1'b1;
    drain();

    // Randomised traffic over compressed frames
    rand_mode = 1'b1;
    hcount = '0; vcount = 10'd470;
    for (int n = 0; n < 3000; n++) begin
      step();
      hcount = hcount + 10'd1;
      if (hcount == 10'd4) begin
        hcount = '0;
        vcount = vcount + 10'd1;
        if (vcount == 10'd525) vcount = '0;
        else if (vcount == 10'd20) vcount = 10'd470;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
